// File: rtl/revelar_celdas.sv
// revelar_celdas: cell-reveal responder for the 8x8 minesweeper board.
// Accepts reveal / flag-toggle requests at the cursor cell, owns the game-state
// matrix mJ read by the renderer, flood-fills zero cells one neighbour per cycle
// and raises sticky lose / win status.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   req_flag               1 = toggle flag, 0 = reveal
//   req_pos_x / req_pos_y  cell column / row
//   numero_bombas          bomb count, stable between resets
//   mBombas, mNum          bomb map and neighbour counts, indexed [y][x]
//   mJ                     cell state: 0 hidden, 1 revealed, 2 flagged, 3 exploded
//   revelados              number of revealed cells
//   perdio, gano           sticky lost / won
//   busy                   flood-fill in progress
module revelar_celdas #(
  parameter int unsigned QDEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_flag,
  input  logic [2:0]             req_pos_x,
  input  logic [2:0]             req_pos_y,
  input  logic [5:0]             numero_bombas,
  input  logic [7:0][7:0][3:0]   mBombas,
  input  logic [7:0][7:0][3:0]   mNum,
  output logic [7:0][7:0][3:0]   mJ,
  output logic [6:0]             revelados,
  output logic                   perdio,
  output logic                   gano,
  output logic                   busy
);

  localparam int unsigned QAW = $clog2(QDEPTH);
  localparam int unsigned CW  = 7;

  localparam logic [3:0] CELL_HIDDEN   = 4'h0;
  localparam logic [3:0] CELL_REVEALED = 4'h1;
  localparam logic [3:0] CELL_FLAGGED  = 4'h2;
  localparam logic [3:0] CELL_EXPLODED = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLOOD_POP,
    S_FLOOD_NB,
    S_LOST,
    S_WON
  } state_t;

  state_t state, next_state;

  // registered request, consumed by IDLE on the following edge
  logic       pend_valid;
  logic       pend_flag;
  logic [2:0] pend_x;
  logic [2:0] pend_y;

  // flood queue of {y,x} cell indices
  logic [5:0]   q_mem [QDEPTH];
  logic [QAW-1:0] q_head, q_tail;
  logic [QAW:0]   q_count;

  logic [5:0] cur;
  logic [2:0] k;

  // combinational control
  logic       xfer;
  logic       win;
  logic       cell_we;
  logic [2:0] cell_y, cell_x;
  logic [3:0] cell_val;
  logic       rev_inc;
  logic       push, pop;
  logic [5:0] push_idx;
  logic [3:0] pend_cell;

  // neighbour addressing
  logic [3:0] dy, dx;
  logic [3:0] ny4, nx4;
  logic       nb_in_range;
  logic [2:0] nb_y, nb_x;

  assign req_ready = (state == S_IDLE);
  assign xfer      = req_valid && req_ready;
  assign win       = (revelados == (CW'(64) - {1'b0, numero_bombas}));
  assign pend_cell = mJ[pend_y][pend_x];

  // neighbour offset for k = NW, N, NE, W, E, SW, S, SE (two's complement)
  always_comb begin
    dy = 4'h0;
    dx = 4'h0;
    case (k)
      3'd0: begin dy = 4'hF; dx = 4'hF; end
      3'd1: begin dy = 4'hF; dx = 4'h0; end
      3'd2: begin dy = 4'hF; dx = 4'h1; end
      3'd3: begin dy = 4'h0; dx = 4'hF; end
      3'd4: begin dy = 4'h0; dx = 4'h1; end
      3'd5: begin dy = 4'h1; dx = 4'hF; end
      3'd6: begin dy = 4'h1; dx = 4'h0; end
      default: begin dy = 4'h1; dx = 4'h1; end
    endcase
  end

  // bit 3 set means the neighbour fell off the board (-1 or 8); no wrap
  assign ny4         = {1'b0, cur[5:3]} + dy;
  assign nx4         = {1'b0, cur[2:0]} + dx;
  assign nb_in_range = !ny4[3] && !nx4[3];
  assign nb_y        = ny4[2:0];
  assign nb_x        = nx4[2:0];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state and datapath control
  always_comb begin
    next_state = state;
    cell_we    = 1'b0;
    cell_y     = 3'd0;
    cell_x     = 3'd0;
    cell_val   = CELL_HIDDEN;
    rev_inc    = 1'b0;
    push       = 1'b0;
    push_idx   = 6'd0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (win) begin
          next_state = S_WON;
        end else if (pend_valid) begin
          cell_y = pend_y;
          cell_x = pend_x;
          if (pend_flag) begin
            if (pend_cell == CELL_HIDDEN) begin
              cell_we  = 1'b1;
              cell_val = CELL_FLAGGED;
            end else if (pend_cell == CELL_FLAGGED) begin
              cell_we  = 1'b1;
              cell_val = CELL_HIDDEN;
            end
          end else if (pend_cell == CELL_HIDDEN) begin
            cell_we = 1'b1;
            if (mBombas[pend_y][pend_x] != 4'h0) begin
              cell_val   = CELL_EXPLODED;
              next_state = S_LOST;
            end else begin
              cell_val = CELL_REVEALED;
              rev_inc  = 1'b1;
              if (mNum[pend_y][pend_x] == 4'h0) begin
                push       = 1'b1;
                push_idx   = {pend_y, pend_x};
                next_state = S_FLOOD_POP;
              end
            end
          end
        end
      end
      S_FLOOD_POP: begin
        if (q_count == '0) begin
          next_state = win ? S_WON : S_IDLE;
        end else begin
          pop        = 1'b1;
          next_state = S_FLOOD_NB;
        end
      end
      S_FLOOD_NB: begin
        cell_y = nb_y;
        cell_x = nb_x;
        // cell is marked revealed in the same cycle it is queued, so no duplicates
        if (nb_in_range && (mJ[nb_y][nb_x] == CELL_HIDDEN) &&
            (mBombas[nb_y][nb_x] == 4'h0)) begin
          cell_we  = 1'b1;
          cell_val = CELL_REVEALED;
          rev_inc  = 1'b1;
          if (mNum[nb_y][nb_x] == 4'h0) begin
            push     = 1'b1;
            push_idx = {nb_y, nb_x};
          end
        end
        if (k == 3'd7) next_state = S_FLOOD_POP;
      end
      default: ;
    endcase
  end

  // game state, status flags, request register and queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mJ         <= '0;
      revelados  <= '0;
      perdio     <= 1'b0;
      gano       <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_flag  <= 1'b0;
      pend_x     <= 3'd0;
      pend_y     <= 3'd0;
      q_head     <= '0;
      q_tail     <= '0;
      q_count    <= '0;
      cur        <= 6'd0;
      k          <= 3'd0;
    end else begin
      if (cell_we) mJ[cell_y][cell_x] <= cell_val;
      if (rev_inc) revelados <= revelados + CW'(1);
      perdio <= (next_state == S_LOST);
      gano   <= (next_state == S_WON);
      busy   <= (next_state == S_FLOOD_POP) || (next_state == S_FLOOD_NB);

      // a request waiting during a flood is kept; terminal states drop it
      if (state == S_IDLE)                          pend_valid <= xfer;
      else if ((state == S_LOST) || (state == S_WON)) pend_valid <= 1'b0;
      if (xfer) begin
        pend_flag <= req_flag;
        pend_x    <= req_pos_x;
        pend_y    <= req_pos_y;
      end

      if (push) q_tail <= q_tail + QAW'(1);
      if (pop)  q_head <= q_head + QAW'(1);
      if (push)     q_count <= q_count + (QAW+1)'(1);
      else if (pop) q_count <= q_count - (QAW+1)'(1);

      if (pop) begin
        cur <= q_mem[q_head];
        k   <= 3'd0;
      end else if (state == S_FLOOD_NB) begin
        k <= k + 3'd1;
      end
    end
  end

  // queue storage
  always_ff @(posedge clk) begin
    if (push) q_mem[q_tail] <= push_idx;
  end

endmodule

// File: tb/tb_revelar_celdas.sv
// Scoreboard bench for revelar_celdas: directed game scenarios plus random games,
// checked against a board-level minesweeper model.
module tb_revelar_celdas;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_flag;
  logic [2:0]           req_pos_x;
  logic [2:0]           req_pos_y;
  logic [5:0]           numero_bombas;
  logic [7:0][7:0][3:0] mBombas;
  logic [7:0][7:0][3:0] mNum;
  logic [7:0][7:0][3:0] mJ;
  logic [6:0]           revelados;
  logic                 perdio;
  logic                 gano;
  logic                 busy;

  revelar_celdas #(.QDEPTH(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_flag(req_flag), .req_pos_x(req_pos_x), .req_pos_y(req_pos_y),
    .numero_bombas(numero_bombas), .mBombas(mBombas), .mNum(mNum),
    .mJ(mJ), .revelados(revelados), .perdio(perdio), .gano(gano), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] mj;
    logic [6:0]   rev;
    logic         perdio;
    logic         gano;
    logic         ready;
    logic         bsy;
    logic [31:0]  lat;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;
  logic sample = 1'b0;
  int   act_lat;
  logic act_busy;

  // board model
  int bomb_m [8][8];
  int num_m  [8][8];
  int mj_m   [8][8];
  int rev_m, nb_m;
  bit lost_m, won_m;

  function automatic void check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void clear_bombs();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) bomb_m[y][x] = 0;
  endfunction

  // neighbour counts from the bomb layout; bomb encodings use random nonzero values
  function automatic void build_map();
    nb_m = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int c;
        c = 0;
        nb_m += bomb_m[y][x];
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && (y + dy >= 0) && (y + dy < 8) &&
                (x + dx >= 0) && (x + dx < 8))
              c += bomb_m[y + dy][x + dx];
        num_m[y][x]   = c;
        mNum[y][x]    = 4'(c);
        mBombas[y][x] = (bomb_m[y][x] != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
    end
    numero_bombas = 6'(nb_m);
  endfunction

  function automatic void model_reset();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) mj_m[y][x] = 0;
    rev_m  = 0;
    lost_m = 0;
    won_m  = 0;
  endfunction

  // fl: a flood ran; nz: number of zero cells whose neighbourhood was opened
  function automatic void model_req(input bit f, input int x, input int y,
                                    output bit fl, output int nz);
    int work[$];
    int c, cy, cx, ny, nx;
    fl = 0;
    nz = 0;
    if (lost_m || won_m) return;
    if (f) begin
      if (mj_m[y][x] == 0)      mj_m[y][x] = 2;
      else if (mj_m[y][x] == 2) mj_m[y][x] = 0;
    end else if (mj_m[y][x] == 0) begin
      if (bomb_m[y][x] != 0) begin
        mj_m[y][x] = 3;
        lost_m = 1;
      end else begin
        mj_m[y][x] = 1;
        rev_m++;
        if (num_m[y][x] == 0) begin
          fl = 1;
          work.push_back(y * 8 + x);
        end
        while (work.size() > 0) begin
          c  = work.pop_front();
          nz++;
          cy = c / 8;
          cx = c % 8;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              ny = cy + dy;
              nx = cx + dx;
              if ((dy != 0 || dx != 0) && ny >= 0 && ny < 8 && nx >= 0 && nx < 8) begin
                if (mj_m[ny][nx] == 0 && bomb_m[ny][nx] == 0) begin
                  mj_m[ny][nx] = 1;
                  rev_m++;
                  if (num_m[ny][nx] == 0) work.push_back(ny * 8 + nx);
                end
              end
            end
          end
        end
      end
    end
    if (!lost_m && rev_m == 64 - nb_m) won_m = 1;
  endfunction

  task automatic check_reset(input string nm);
    check({nm, "/mj"}, 256'(mJ), 256'd0);
    check({nm, "/rev"}, 256'(revelados), 256'd0);
    check({nm, "/perdio"}, 256'(perdio), 256'd0);
    check({nm, "/gano"}, 256'(gano), 256'd0);
    check({nm, "/busy"}, 256'(busy), 256'd0);
    check({nm, "/ready"}, 256'(req_ready), 256'd1);
  endtask

  // load the current bomb layout and reset both DUT and model
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    build_map();
    #1 check_reset(nm);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic issue(input bit f, input int x, input int y);
    @(negedge clk);
    req_flag  = f;
    req_pos_x = 3'(x);
    req_pos_y = 3'(y);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // count edges from the transfer edge until busy is low again
  task automatic wait_done();
    act_busy = 1'b0;
    @(posedge clk);
    #1 act_lat = 1;
    while (busy && act_lat < 700) begin
      act_busy = 1'b1;
      @(posedge clk);
      #1 act_lat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input string nm, input bit fl, input int nz);
    snap_t s;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) s.mj[(y * 8 + x) * 4 +: 4] = 4'(mj_m[y][x]);
    s.rev    = 7'(rev_m);
    s.perdio = lost_m;
    s.gano   = won_m;
    s.ready  = !(lost_m || won_m);
    s.bsy    = fl;
    s.lat    = fl ? 32'(2 + 9 * nz) : 32'd1;
    exp_q.push_back(s);
    name_q.push_back(nm);
    @(posedge clk);
    #1 sample = 1'b1;
    @(posedge clk);
    #1 sample = 1'b0;
  endtask

  task automatic run_req(input bit f, input int x, input int y, input string nm);
    bit fl;
    int nz;
    issue(f, x, y);
    model_req(f, x, y, fl, nz);
    wait_done();
    push_snap(nm, fl, nz);
  endtask

  // monitor: compare DUT state against the oldest expected snapshot
  always @(negedge clk) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: got sample expected queued snapshot");
      end else begin
        snap_t e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "/mj"}, 256'(mJ), 256'(e.mj));
        check({nm, "/rev"}, 256'(revelados), 256'(e.rev));
        check({nm, "/perdio"}, 256'(perdio), 256'(e.perdio));
        check({nm, "/gano"}, 256'(gano), 256'(e.gano));
        check({nm, "/ready"}, 256'(req_ready), 256'(e.ready));
        check({nm, "/busy_seen"}, 256'(act_busy), 256'(e.bsy));
        check({nm, "/latency"}, 256'(act_lat), 256'(e.lat));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_flag  = 1'b0;
    req_pos_x = 3'd0;
    req_pos_y = 3'd0;
    clear_bombs();
    build_map();
    #1 check_reset("por");
    #20;

    // flag toggle and reveal of a flagged cell
    clear_bombs();
    bomb_m[0][0] = 1;
    do_reset("rst_flag");
    run_req(1, 3, 3, "flag_set");
    run_req(1, 3, 3, "flag_clear");
    run_req(1, 3, 3, "flag_again");
    run_req(0, 3, 3, "reveal_flagged");

    // bomb hit, then requests ignored
    clear_bombs();
    bomb_m[2][5] = 1;
    do_reset("rst_bomb");
    run_req(0, 5, 2, "bomb_hit");
    run_req(0, 0, 0, "lost_reveal");
    run_req(1, 1, 1, "lost_flag");

    // numbered cell only
    clear_bombs();
    bomb_m[0][0] = 1;
    bomb_m[0][1] = 1;
    do_reset("rst_num");
    run_req(0, 1, 1, "numbered");

    // full flood and win
    clear_bombs();
    bomb_m[7][7] = 1;
    do_reset("rst_flood");
    run_req(0, 0, 0, "full_flood");
    run_req(1, 2, 2, "won_flag");

    // flag barrier
    do_reset("rst_barrier");
    run_req(1, 4, 4, "barrier_flag");
    run_req(0, 0, 0, "barrier_flood");
    run_req(1, 4, 4, "barrier_unflag");

    // reset in the middle of a flood
    do_reset("rst_mid");
    issue(0, 0, 0);
    repeat (20) @(posedge clk);
    #1 check("mid/busy", 256'(busy), 256'd1);
    rst = 1'b1;
    #1 check_reset("mid_abort");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_req(0, 3, 3, "after_abort");

    // random games
    for (int g = 0; g < 4; g++) begin
      int n, placed;
      clear_bombs();
      n = $urandom_range(1, 8);
      placed = 0;
      while (placed < n) begin
        int by, bx;
        by = $urandom_range(0, 7);
        bx = $urandom_range(0, 7);
        if (bomb_m[by][bx] == 0) begin
          bomb_m[by][bx] = 1;
          placed++;
        end
      end
      do_reset("rst_rand");
      for (int r = 0; r < 12; r++)
        run_req($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7), "rand");
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
